// File: rtl/auth_tx_if.sv
// auth_tx_if: request/status bundle between a controller and the authentication transmitter
interface auth_tx_if;
  logic go;
  logic stop;
  logic tx;
  logic busy;
  logic sent;
  logic link_on;
  modport master (output go, stop, input tx, busy, sent, link_on);
  modport slave (input go, stop, output tx, busy, sent, link_on);
endinterface

// File: rtl/auth_tx.sv
// auth_tx: sends single 8N1 'g'/'s' power-up/power-down bytes from one-deep request slot
module auth_tx #(
  parameter int BAUD_DIV = 5208
) (
  input logic       clk,
  input logic       rst_n,
  auth_tx_if.slave  bus
);
  localparam int BW = $clog2(BAUD_DIV);
  typedef enum logic {IDLE, XMIT} state_t;
  typedef enum logic [1:0] {EMPTY, CMD_G, CMD_S} slot_t;
  state_t        state_q;
  slot_t         slot_q, slot_d;
  logic [8:0]    sh_q;
  logic [BW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic          is_g_q, tx_q, busy_q, sent_q, link_q;
  logic          baud_end;
  assign baud_end = baud_q == BW'(BAUD_DIV - 1);
  // Last request wins with stop dominating; an idle FSM consumes the pending command
  always_comb begin
    slot_d = bus.stop ? CMD_S : bus.go ? CMD_G : (state_q == IDLE) ? EMPTY : slot_q;
  end
  // Request slot register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= EMPTY;
    else        slot_q <= slot_d;
  end
  // Frame FSM: start bit driven directly, then data+stop shifted out LSB first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      is_g_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
      link_q  <= 1'b0;
    end else begin
      sent_q <= 1'b0;
      if (state_q == IDLE) begin
        tx_q <= 1'b1;
        if (slot_q != EMPTY) begin
          sh_q    <= {1'b1, (slot_q == CMD_G) ? 8'h67 : 8'h73};
          is_g_q  <= slot_q == CMD_G;
          tx_q    <= 1'b0;
          busy_q  <= 1'b1;
          baud_q  <= '0;
          bit_q   <= '0;
          state_q <= XMIT;
        end
      end else if (baud_end) begin
        baud_q <= '0;
        if (bit_q == 4'd9) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          sent_q  <= 1'b1;
          link_q  <= is_g_q;
          tx_q    <= 1'b1;
        end else begin
          tx_q  <= sh_q[0];
          sh_q  <= {1'b1, sh_q[8:1]};
          bit_q <= bit_q + 4'd1;
        end
      end else begin
        baud_q <= baud_q + 1'b1;
      end
    end
  end
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.sent    = sent_q;
  assign bus.link_on = link_q;
endmodule

// File: doc/auth_tx.md
# auth_tx

Authentication command transmitter for the Segway power-up protocol. Sends single 8N1 UART bytes: 'g' (0x67) to request power-up and 's' (0x73) to request power-down. It is driven by one-cycle go/stop requests from the remote/bench controller. Its TX line feeds the RX input of the platform's authentication receiver.

## Interface
- BAUD_DIV, default 5208: clk cycles per UART bit; must be ≥ 2 (5208 gives 9600 baud at 50 MHz).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle request to transmit 'g' (0x67).
- stop  in  1  one-cycle request to transmit 's' (0x73).
- TX  out  1  serial line: idle high, 8N1, LSB first.
- busy  out  1  high while a frame is in flight.
- sent  out  1  one-cycle pulse when a frame's stop bit completes.
- link_on  out  1  1 after a completed 'g' frame, 0 after a completed 's' frame.

## Operation
- Reset values: TX=1, busy=0, sent=0, link_on=0; request slot empty; FSM in IDLE.
- **Request slot**
  - The slot holds one pending command: empty, G, or S.
  - A go or stop pulse overwrites the slot. Last request wins, and requests never queue deeper than one.
  - go and stop sampled high on the same edge: slot = S (stop wins).
  - Requests are accepted in every state, including while busy.
- **FSM states: IDLE, XMIT**
  - IDLE: if the slot is non-empty, load the frame {1, byte[7:0], 0} into a 10-bit shift register, clear the slot, drive TX=0, set busy=1, and go to XMIT.
  - XMIT: the baud counter counts 0..BAUD_DIV-1. At terminal count it shifts to the next bit and increments the bit counter (0..9).
  - XMIT end: when the terminal count of bit 9 (the stop bit) occurs, go to IDLE, set busy=0, pulse sent, and set link_on to 1 for 'g' or 0 for 's'.
- TX is a registered output driven from shift-register bit 0. TX never glitches and is 1 whenever the FSM is in IDLE.
- **Counter widths:** baud counter $clog2(BAUD_DIV) bits; bit counter 4 bits. Both clear on frame start.
- **Redundancy:** no suppression. 'g' while link_on=1 is still transmitted.
- **Reset mid-frame:** takes effect immediately.
  - TX→1, busy→0, slot cleared.
  - The aborted frame produces no sent pulse and leaves link_on=0.

## Timing
- A request sampled at edge N while idle with an empty slot loads the slot at edge N.
- At edge N+1, TX=0 (start bit) and busy=1.
- Each bit lasts exactly BAUD_DIV cycles. A frame lasts 10·BAUD_DIV cycles.
- At edge N+1+10·BAUD_DIV: busy=0, sent=1 for one cycle, link_on updated.
- Back-to-back frames: if the slot is non-empty when the frame ends, the next start bit begins one edge later. The line shows at least 1 cycle of idle-high between frames, beyond the stop bit.
- sent and busy are never high in the same cycle.

## Test plan
- **Single 'g', BAUD_DIV=4:**
  - Stimulus: go pulse at edge N.
  - TX from edge N+1, each value held 4 cycles: 0,1,1,1,0,0,1,1,0,1.
  - sent pulses at N+41; busy high N+1..N+40; link_on=1 after N+41.
- **'s' after 'g':**
  - Stimulus: stop pulse at edge N.
  - TX frame bits: 0,1,1,0,0,1,1,1,0,1.
  - link_on 1→0 coincident with sent.
- **Overwrite during busy:**
  - Stimulus: go at edge 0; during that frame, go then stop.
  - Exactly two frames appear: 'g' then 's'. Exactly two sent pulses; final link_on=0.
- **Simultaneous go and stop while idle:** one 's' frame only; link_on stays 0.
- **Reset mid-frame:**
  - Stimulus: rst_n low during data bit 4 of a 'g' frame.
  - TX=1 and busy=0 immediately; no sent pulse; link_on=0.
  - A go after reset release produces a complete, correct 'g' frame.
- **Loopback, BAUD_DIV=5208:**
  - Setup: TX wired to the platform authentication receiver, with matching baud.
  - go → receiver powers up.
  - stop with rider present → receiver stays up; then rider off → receiver powers down.
